// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Pulls scan bytes from a PS/2 receiver FIFO, decodes make/break codes
//   (including E0-extended keys and the E1 Pause sequence), tracks which
//   keys are currently held, and queues press/release events for a consumer.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   clrn           asynchronous active-low reset
//   kb_data[7:0]   scan byte at the head of the receiver FIFO
//   kb_ready       receiver FIFO non-empty
//   kb_nextdata_n  active-low one-cycle pop strobe back to the receiver
//   ev_valid       event queue non-empty
//   ev_ready       consumer accepts the head event
//   ev_code[7:0]   head event scan code
//   ev_ext         head event carried the E0 prefix
//   ev_make        head event is a press (1) or release (0)
//   held_cnt[3:0]  number of occupied key slots
//   press_cnt      count of accepted new presses (wraps)
//   err            one-cycle pulse on protocol, rollover or unknown-break error
//   ev_drop        sticky: an event was lost because the queue was full
module ps2_key_tracker #(
    parameter int MAX_KEYS  = 4,
    parameter int CNT_W     = 8,
    parameter int EVQ_DEPTH = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       kb_data,
    input  logic             kb_ready,
    output logic             kb_nextdata_n,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_make,
    output logic [3:0]       held_cnt,
    output logic [CNT_W-1:0] press_cnt,
    output logic             err,
    output logic             ev_drop
);

    localparam int AW = $clog2(EVQ_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXTBRK,
        S_SKIP
    } state_t;

    // ------------------------------------------------------------------
    // Stage 0: byte intake. The receiver needs a couple of cycles to
    // advance its head after a pop, so a new capture waits until neither
    // of the two previous edges popped.
    // ------------------------------------------------------------------
    logic       pop_q1;
    logic       pop_q2;
    logic       take;
    logic [7:0] byte_q;
    logic       byte_vld;

    assign take          = kb_ready && !pop_q1 && !pop_q2;
    assign kb_nextdata_n = ~pop_q1;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pop_q1   <= 1'b0;
            pop_q2   <= 1'b0;
            byte_vld <= 1'b0;
            byte_q   <= 8'h00;
        end else begin
            pop_q1   <= take;
            pop_q2   <= pop_q1;
            byte_vld <= take;
            if (take) begin
                byte_q <= kb_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: parser, key table and counters act on the captured byte.
    // ------------------------------------------------------------------
    state_t     state;
    state_t     state_nx;
    logic [2:0] skip_cnt;
    logic [2:0] skip_nx;
    logic       code_done;
    logic       code_ext;
    logic       code_make;
    logic       proto_err;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= S_IDLE;
            skip_cnt <= 3'd0;
        end else begin
            state    <= state_nx;
            skip_cnt <= skip_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        skip_nx   = skip_cnt;
        code_done = 1'b0;
        code_ext  = 1'b0;
        code_make = 1'b0;
        proto_err = 1'b0;
        if (byte_vld) begin
            if (state == S_SKIP) begin
                // Pause sends E1 + 7 bytes; everything inside is swallowed,
                // including its second E1.
                skip_nx = skip_cnt - 3'd1;
                if (skip_cnt == 3'd1) begin
                    state_nx = S_IDLE;
                end
            end else if (byte_q == 8'hE1) begin
                state_nx = S_SKIP;
                skip_nx  = 3'd7;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (byte_q == 8'hE0) begin
                            state_nx = S_EXT;
                        end else if (byte_q == 8'hF0) begin
                            state_nx = S_BRK;
                        end else if (byte_q == 8'hAA || byte_q == 8'hFA ||
                                     byte_q == 8'hEE || byte_q == 8'hFE) begin
                            // keyboard status/ack bytes, not key codes
                            state_nx = S_IDLE;
                        end else begin
                            code_done = 1'b1;
                            code_make = 1'b1;
                        end
                    end
                    S_EXT: begin
                        if (byte_q == 8'hF0) begin
                            state_nx = S_EXTBRK;
                        end else begin
                            code_done = 1'b1;
                            code_make = 1'b1;
                            code_ext  = 1'b1;
                            state_nx  = S_IDLE;
                        end
                    end
                    S_BRK, S_EXTBRK: begin
                        state_nx = S_IDLE;
                        if (byte_q == 8'hE0 || byte_q == 8'hF0) begin
                            proto_err = 1'b1;
                        end else begin
                            code_done = 1'b1;
                            code_ext  = (state == S_EXTBRK);
                        end
                    end
                    default: begin
                        state_nx = S_IDLE;
                    end
                endcase
            end
        end
    end

    // Key table lookup: exact {ext, code} hit, and lowest free slot.
    logic [MAX_KEYS-1:0] slot_vld;
    logic [MAX_KEYS-1:0] slot_ext;
    logic [7:0]          slot_code [MAX_KEYS];
    logic                hit;
    logic [2:0]          hit_idx;
    logic                free;
    logic [2:0]          free_idx;

    always_comb begin
        hit      = 1'b0;
        hit_idx  = 3'd0;
        free     = 1'b0;
        free_idx = 3'd0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            if (slot_vld[i] && slot_ext[i] == code_ext && slot_code[i] == byte_q) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (!slot_vld[i]) begin
                free     = 1'b1;
                free_idx = 3'(i);
            end
        end
    end

    logic push;
    logic tbl_set;
    logic tbl_clr;
    logic cnt_inc;
    logic tbl_err;

    always_comb begin
        push    = 1'b0;
        tbl_set = 1'b0;
        tbl_clr = 1'b0;
        cnt_inc = 1'b0;
        tbl_err = 1'b0;
        if (code_done) begin
            if (code_make) begin
                // a make for a key already held is typematic repeat: ignored
                if (!hit) begin
                    push    = 1'b1;
                    cnt_inc = 1'b1;
                    if (free) begin
                        tbl_set = 1'b1;
                    end else begin
                        tbl_err = 1'b1;
                    end
                end
            end else if (hit) begin
                push    = 1'b1;
                tbl_clr = 1'b1;
            end else begin
                tbl_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            slot_vld  <= '0;
            slot_ext  <= '0;
            for (int i = 0; i < MAX_KEYS; i++) begin
                slot_code[i] <= 8'h00;
            end
            press_cnt <= '0;
            err       <= 1'b0;
        end else begin
            for (int i = 0; i < MAX_KEYS; i++) begin
                if (tbl_set && free_idx == 3'(i)) begin
                    slot_vld[i]  <= 1'b1;
                    slot_ext[i]  <= code_ext;
                    slot_code[i] <= byte_q;
                end else if (tbl_clr && hit_idx == 3'(i)) begin
                    slot_vld[i] <= 1'b0;
                end
            end
            if (cnt_inc) begin
                press_cnt <= press_cnt + CNT_W'(1);
            end
            err <= proto_err | tbl_err;
        end
    end

    always_comb begin
        held_cnt = 4'd0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            held_cnt = held_cnt + 4'(slot_vld[i]);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: event queue toward the consumer.
    // ------------------------------------------------------------------
    logic [9:0]  fifo_mem [EVQ_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          fifo_pop;
    logic          push_ok;
    logic [9:0]    head;

    assign ev_valid = (count != '0);
    assign full     = (count == (AW+1)'(EVQ_DEPTH));
    assign fifo_pop = ev_valid && ev_ready;
    // a full queue still takes a push when the head leaves on the same edge
    assign push_ok  = push && (!full || fifo_pop);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ev_drop <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !fifo_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!push_ok && fifo_pop) begin
                count <= count - (AW+1)'(1);
            end
            if (push && !push_ok) begin
                ev_drop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= {byte_q, code_ext, code_make};
        end
    end

    // Storage is not reset, so the head is masked while the queue is empty.
    assign head    = ev_valid ? fifo_mem[rd_ptr] : 10'd0;
    assign ev_code = head[9:2];
    assign ev_ext  = head[1];
    assign ev_make = head[0];

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker
//   Directed bench for ps2_key_tracker. Bytes are offered the way a PS/2
//   receiver FIFO would (head held until the pop strobe), expected events
//   are queued by the stimulus and consumed by an independent monitor.
module tb_ps2_key_tracker;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_ready = 1'b0;
    logic       kb_nextdata_n;
    logic       ev_valid;
    logic       ev_ready = 1'b1;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_make;
    logic [3:0] held_cnt;
    logic [7:0] press_cnt;
    logic       err;
    logic       ev_drop;

    ps2_key_tracker #(.MAX_KEYS(4), .CNT_W(8), .EVQ_DEPTH(4)) dut (
        .clk           (clk),
        .clrn          (clrn),
        .kb_data       (kb_data),
        .kb_ready      (kb_ready),
        .kb_nextdata_n (kb_nextdata_n),
        .ev_valid      (ev_valid),
        .ev_ready      (ev_ready),
        .ev_code       (ev_code),
        .ev_ext        (ev_ext),
        .ev_make       (ev_make),
        .held_cnt      (held_cnt),
        .press_cnt     (press_cnt),
        .err           (err),
        .ev_drop       (ev_drop)
    );

    always #5 clk = ~clk;

    // expected event = {code, ext, make}
    logic [9:0] expq [$];
    logic [9:0] mon_e;
    int         checks   = 0;
    int         errors   = 0;
    int         err_seen = 0;
    int         err_base = 0;
    logic [7:0] exp_press = 8'd0;

    // Monitor: consumes one expected event per accepted DUT event.
    always @(negedge clk) begin
        if (clrn) begin
            if (err) err_seen++;
            if (ev_valid && ev_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got code=%h ext=%b make=%b, required no event",
                             ev_code, ev_ext, ev_make);
                end else begin
                    mon_e = expq.pop_front();
                    if ({ev_code, ev_ext, ev_make} !== mon_e) begin
                        errors++;
                        $display("FAIL event: got code=%h ext=%b make=%b, required code=%h ext=%b make=%b",
                                 ev_code, ev_ext, ev_make, mon_e[9:2], mon_e[1], mon_e[0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Present one byte as receiver head until the DUT strobes the pop.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        kb_data  = b;
        kb_ready = 1'b1;
        while (kb_nextdata_n !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL pop_timeout: got no pop for byte %h, required pop within 20 cycles", b);
        end
        @(posedge clk);
        #1 kb_ready = 1'b0;
    endtask

    task automatic key_make(input logic [7:0] c, input logic ext, input logic expect_ev);
        if (expect_ev) begin
            expq.push_back({c, ext, 1'b1});
            exp_press = exp_press + 8'd1;
        end
        if (ext) send_byte(8'hE0);
        send_byte(c);
    endtask

    task automatic key_break(input logic [7:0] c, input logic ext, input logic expect_ev);
        if (expect_ev) expq.push_back({c, ext, 1'b0});
        if (ext) send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(c);
    endtask

    task automatic settle();
        int n = 0;
        while (expq.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d events outstanding, required 0", expq.size());
            expq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_nextdata_n"}, kb_nextdata_n, 1);
        chk({tag, "_ev_valid"}, ev_valid, 0);
        chk({tag, "_ev_fields"}, {ev_code, ev_ext, ev_make}, 0);
        chk({tag, "_held_cnt"}, held_cnt, 0);
        chk({tag, "_press_cnt"}, press_cnt, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_ev_drop"}, ev_drop, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        clrn = 1'b0;
        #1 check_reset(tag);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        exp_press = 8'd0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check_reset("rst0");
        clrn = 1'b1;
        @(negedge clk);

        // single key press and release
        key_make(8'h1C, 1'b0, 1'b1);
        settle();
        chk("basic_held_after_make", held_cnt, 1);
        key_break(8'h1C, 1'b0, 1'b1);
        settle();
        chk("basic_held_after_break", held_cnt, 0);
        chk("basic_press_cnt", press_cnt, exp_press);

        // extended key with typematic repeat
        key_make(8'h75, 1'b1, 1'b1);
        key_make(8'h75, 1'b1, 1'b0);
        key_break(8'h75, 1'b1, 1'b1);
        settle();
        chk("ext_press_cnt", press_cnt, exp_press);
        chk("ext_held_cnt", held_cnt, 0);

        // same code with and without E0 are distinct keys
        key_make(8'h1C, 1'b0, 1'b1);
        key_make(8'h1C, 1'b1, 1'b1);
        settle();
        chk("dual_held_2", held_cnt, 2);
        key_break(8'h1C, 1'b0, 1'b1);
        settle();
        chk("dual_held_1", held_cnt, 1);
        key_break(8'h1C, 1'b1, 1'b1);
        settle();
        chk("dual_held_0", held_cnt, 0);

        // status bytes in IDLE are ignored
        err_base = err_seen;
        send_byte(8'hAA);
        send_byte(8'hFA);
        send_byte(8'hEE);
        send_byte(8'hFE);
        settle();
        chk("status_press_cnt", press_cnt, exp_press);
        chk("status_err", err_seen - err_base, 0);

        // protocol errors, then parser resumes from IDLE
        send_byte(8'hF0);
        send_byte(8'hE0);
        key_make(8'h1C, 1'b0, 1'b1);
        settle();
        chk("proto_err_brk", err_seen - err_base, 1);
        key_break(8'h1C, 1'b0, 1'b1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'hF0);
        key_make(8'h2C, 1'b0, 1'b1);
        key_break(8'h2C, 1'b0, 1'b1);
        settle();
        chk("proto_err_extbrk", err_seen - err_base, 2);

        // rollover: fifth key with four held
        err_base = err_seen;
        key_make(8'h1C, 1'b0, 1'b1);
        key_make(8'h1B, 1'b0, 1'b1);
        key_make(8'h23, 1'b0, 1'b1);
        key_make(8'h2B, 1'b0, 1'b1);
        settle();
        chk("roll_no_err_yet", err_seen - err_base, 0);
        key_make(8'h34, 1'b0, 1'b1);
        settle();
        chk("roll_err", err_seen - err_base, 1);
        chk("roll_held", held_cnt, 4);
        chk("roll_press_cnt", press_cnt, exp_press);
        key_break(8'h34, 1'b0, 1'b0);
        settle();
        chk("unknown_break_err", err_seen - err_base, 2);
        key_break(8'h1C, 1'b0, 1'b1);
        key_break(8'h1B, 1'b0, 1'b1);
        key_break(8'h23, 1'b0, 1'b1);
        key_break(8'h2B, 1'b0, 1'b1);
        settle();
        chk("roll_held_cleared", held_cnt, 0);

        // queue overflow with a stalled consumer, plus event latency
        ev_ready = 1'b0;
        key_make(8'h15, 1'b0, 1'b1);
        @(posedge clk);
        #1 chk("latency_ev_valid", ev_valid, 1);
        key_make(8'h1D, 1'b0, 1'b1);
        key_make(8'h24, 1'b0, 1'b1);
        key_make(8'h2D, 1'b0, 1'b1);
        key_make(8'h2C, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("drop_flag", ev_drop, 1);
        chk("drop_ev_valid", ev_valid, 1);
        chk("drop_head_code", ev_code, 8'h15);
        ev_ready = 1'b1;
        settle();
        chk("drop_drained", ev_valid, 0);
        chk("drop_sticky", ev_drop, 1);
        do_reset("rst1");

        // Pause sequence swallowed, then a normal key
        send_byte(8'hE1);
        send_byte(8'h14);
        send_byte(8'h77);
        send_byte(8'hE1);
        send_byte(8'hF0);
        send_byte(8'h14);
        send_byte(8'hF0);
        send_byte(8'h77);
        key_make(8'h1C, 1'b0, 1'b1);
        settle();
        chk("skip_press_cnt", press_cnt, 1);
        chk("skip_held_cnt", held_cnt, 1);
        key_break(8'h1C, 1'b0, 1'b1);

        // press counter wraps after 255
        for (int i = 0; i < 254; i++) begin
            key_make(8'h1C, 1'b0, 1'b1);
            key_break(8'h1C, 1'b0, 1'b1);
        end
        settle();
        chk("press_cnt_255", press_cnt, 8'd255);
        key_make(8'h1C, 1'b0, 1'b1);
        settle();
        chk("press_cnt_wrap", press_cnt, 8'd0);

        // reset in the middle of an extended break
        send_byte(8'hE0);
        send_byte(8'hF0);
        @(negedge clk);
        clrn = 1'b0;
        #1 check_reset("rst_mid");
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        exp_press = 8'd0;
        @(negedge clk);
        key_make(8'h1C, 1'b0, 1'b1);
        settle();
        chk("post_rst_held", held_cnt, 1);
        chk("post_rst_press", press_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
